pc_sequencer: RTL and testbench

//   Parametrised program-counter sequencer for the control path: holds the PC, applies
//   jmp/cal/ret from the decoder and keeps return addresses in an internal LIFO of

---
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a return-address LIFO, stall, and overflow/underflow fault detection.
// Define PC_SEQ_IRQ_EN to add the irq/irq_ack interrupt entry path.
module pc_sequencer #(
    parameter int                    PC_WIDTH    = 8,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_ADDR  = '0,
    parameter logic [PC_WIDTH-1:0]   IRQ_VECTOR  = 8'hF0,
    parameter int                    DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
`ifdef PC_SEQ_IRQ_EN
    input  logic                irq,
    output logic                irq_ack,
`endif
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic [DEPTH_W-1:0]  stack_depth,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [DEPTH_W-1:0]     depth_q, depth_d;
    logic [1:0]             code_q, code_d;
    logic [PC_WIDTH-1:0]    stack_q [STACK_DEPTH];

    logic                   push_en;
    logic [PC_WIDTH-1:0]    push_data;
    logic [IDX_W-1:0]       push_idx;
    logic [IDX_W-1:0]       top_idx;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic                   full;
    logic                   empty;

`ifdef PC_SEQ_IRQ_EN
    logic                   irq_mask_q, irq_mask_d;
    logic                   irq_ack_q, irq_ack_d;
`endif

    assign pc_inc   = pc_q + PC_WIDTH'(1);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign push_idx = IDX_W'(depth_q);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));

    // Row order below is the event priority; the first match wins.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        code_d    = code_q;
        push_en   = 1'b0;
        push_data = pc_inc;
`ifdef PC_SEQ_IRQ_EN
        irq_mask_d = irq_mask_q;
        irq_ack_d  = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end
`ifdef PC_SEQ_IRQ_EN
                else if (irq && !irq_mask_q && !full) begin
                    push_en    = 1'b1;
                    push_data  = pc_q;
                    depth_d    = depth_q + DEPTH_W'(1);
                    pc_d       = IRQ_VECTOR;
                    irq_ack_d  = 1'b1;
                    irq_mask_d = 1'b1;
                end
`endif
                else if (cal && ret) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b11;
                end else if (cal && full) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b01;
                end else if (ret && empty) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b10;
                end else if (ret) begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
`ifdef PC_SEQ_IRQ_EN
                    irq_mask_d = 1'b0;
`endif
                end else if (cal) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DEPTH_W'(1);
                    pc_d    = jmp_addr;
                end else if (jmp) begin
                    pc_d = jmp_addr;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            code_q  <= 2'b00;
`ifdef PC_SEQ_IRQ_EN
            irq_mask_q <= 1'b0;
            irq_ack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            code_q  <= code_d;
`ifdef PC_SEQ_IRQ_EN
            irq_mask_q <= irq_mask_d;
            irq_ack_q  <= irq_ack_d;
`endif
        end
    end

    // Stack storage is deliberately not reset; only depth_q defines validity.
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            stack_q[push_idx] <= push_data;
        end
    end

    assign instr_addr  = pc_q;
    assign stack_depth = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = code_q;
`ifdef PC_SEQ_IRQ_EN
    assign irq_ack     = irq_ack_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized control traffic,
// all compared against a queue-based reference model of the sequencing rules.
module tb_pc_sequencer;

    localparam int PW = 8;
    localparam int SD = 8;
    localparam int DW = $clog2(SD + 1);
    localparam int PC_MASK = (1 << PW) - 1;
    localparam int IRQ_VEC = 'hF0;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          jmp;
    logic          cal;
    logic          ret;
    logic [PW-1:0] jmp_addr;
    logic [PW-1:0] instr_addr;
    logic [DW-1:0] stack_depth;
    logic          stack_full;
    logic          stack_empty;
    logic          fault;
    logic [1:0]    fault_code;
    logic          irq_in = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    logic          irq_ack;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int  m_pc    = 0;
    int  m_stack[$];
    bit  m_fault = 1'b0;
    int  m_code  = 0;
    bit  m_mask  = 1'b0;
    bit  m_ack   = 1'b0;

    pc_sequencer #(
        .PC_WIDTH   (PW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jmp        (jmp),
        .cal        (cal),
        .ret        (ret),
`ifdef PC_SEQ_IRQ_EN
        .irq        (irq_in),
        .irq_ack    (irq_ack),
`endif
        .jmp_addr   (jmp_addr),
        .instr_addr (instr_addr),
        .stack_depth(stack_depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input bit j, input bit c,
                             input bit rt, input int addr, input bit irq);
        m_ack = 1'b0;
        if (!r) begin
            m_pc    = 0;
            m_stack.delete();
            m_fault = 1'b0;
            m_code  = 0;
            m_mask  = 1'b0;
        end else if (m_fault || s) begin
            // everything holds
        end else if (irq && !m_mask && m_stack.size() < SD) begin
            m_stack.push_back(m_pc);
            m_pc   = IRQ_VEC;
            m_ack  = 1'b1;
            m_mask = 1'b1;
        end else if (c && rt) begin
            m_fault = 1'b1;
            m_code  = 3;
        end else if (c && m_stack.size() == SD) begin
            m_fault = 1'b1;
            m_code  = 1;
        end else if (rt && m_stack.size() == 0) begin
            m_fault = 1'b1;
            m_code  = 2;
        end else if (rt) begin
            m_pc   = m_stack.pop_back();
            m_mask = 1'b0;
        end else if (c) begin
            m_stack.push_back((m_pc + 1) & PC_MASK);
            m_pc = addr;
        end else if (j) begin
            m_pc = addr;
        end else begin
            m_pc = (m_pc + 1) & PC_MASK;
        end
    endtask

    task automatic checkAll();
        checkOutput("instr_addr",  32'(instr_addr),  32'(m_pc));
        checkOutput("stack_depth", 32'(stack_depth), 32'(m_stack.size()));
        checkOutput("stack_full",  32'(stack_full),  32'(m_stack.size() == SD));
        checkOutput("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        checkOutput("fault",       32'(fault),       32'(m_fault));
        checkOutput("fault_code",  32'(fault_code),  32'(m_code));
`ifdef PC_SEQ_IRQ_EN
        checkOutput("irq_ack",     32'(irq_ack),     32'(m_ack));
`endif
    endtask

    // Drive one cycle of controls, advance the model, then sample after the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit j, input bit c,
                                 input bit rt, input int addr);
        rst      = r;
        stall    = s;
        jmp      = j;
        cal      = c;
        ret      = rt;
        jmp_addr = PW'(addr);
`ifdef PC_SEQ_IRQ_EN
        modelStep(r, s, j, c, rt, addr, irq_in);
`else
        modelStep(r, s, j, c, rt, addr, 1'b0);
`endif
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        // 1: reset then free-running count
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_reset_pc", 32'(instr_addr), 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t1_pc_after4", 32'(instr_addr), 32'h4);

        // 2: call and return
        applyStimulus(1, 0, 1, 0, 0, 'h10);
        applyStimulus(1, 0, 0, 1, 0, 'h40);
        checkOutput("t2_call_pc", 32'(instr_addr), 32'h40);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("t2_ret_pc", 32'(instr_addr), 32'h11);

        // 3: fill the stack, overflow, frozen until reset
        for (int i = 0; i < SD; i++) applyStimulus(1, 0, 0, 1, 0, 'h20 + i * 4);
        checkOutput("t3_full", 32'(stack_full), 32'h1);
        applyStimulus(1, 0, 0, 1, 0, 'h99);
        checkOutput("t3_overflow_code", 32'(fault_code), 32'h1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 1, 'h55);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // 4: underflow, then cal&ret together
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("t4_underflow_code", 32'(fault_code), 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 'h30);
        checkOutput("t4_calret_code", 32'(fault_code), 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // 5: stall holds a pending call
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, 'h70);
        applyStimulus(1, 0, 0, 1, 0, 'h70);
        checkOutput("t5_depth", 32'(stack_depth), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // 6: PC wrap on the pushed return address
        applyStimulus(1, 0, 1, 0, 0, 'hFF);
        applyStimulus(1, 0, 0, 1, 0, 'h20);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("t6_wrap_ret", 32'(instr_addr), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);

`ifdef PC_SEQ_IRQ_EN
        applyStimulus(1, 0, 1, 0, 0, 'h05);
        irq_in = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("irq_vector", 32'(instr_addr), 32'hF0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        irq_in = 1'b0;
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("irq_ret", 32'(instr_addr), 32'h05);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
`ifdef PC_SEQ_IRQ_EN
            irq_in = ($urandom_range(0, 5) == 0);
`endif
            applyStimulus(($urandom_range(0, 39) != 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
